gumnut_data_arbiter: RTL and testbench
======================================

Name: gumnut_data_arbiter

Overview:
- Two-master, one-slave arbiter for the 8-bit Wishbone-style data bus of the Gumnut core.
- Master 0 is the core data port; master 1 is a secondary requester (DMA or debug loader).
- Shares the single data memory between the two masters, holds the grant for the whole cycle (cyc_i), and terminates hung accesses with an error pulse from a watchdog.

Parameters:
- ADDR_W, 8, address width of masters and slave.
- DATA_W, 8, data width.
- TIMEOUT, 15, cycles with stb asserted and no ack before error termination; legal range 1..255.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- m0_cyc_i, m1_cyc_i  in  1  master bus-cycle request; held high for the entire locked cycle.
- m0_stb_i, m1_stb_i  in  1  master transfer strobe.
- m0_we_i, m1_we_i  in  1  master write enable.
- m0_adr_i, m1_adr_i  in  ADDR_W  master address.
- m0_dat_i, m1_dat_i  in  DATA_W  master write data.
- m0_dat_o, m1_dat_o  out  DATA_W  read data; s_dat_i broadcast to both masters.
- m0_ack_o, m1_ack_o  out  1  transfer acknowledge.
- m0_err_o, m1_err_o  out  1  timeout error, single-cycle pulse.
- s_cyc_o, s_stb_o, s_we_o  out  1  slave control.
- s_adr_o  out  ADDR_W  slave address.
- s_dat_o  out  DATA_W  slave write data.
- s_dat_i  in  DATA_W  slave read data.
- s_ack_i  in  1  slave acknowledge.
- grant_o  out  2  one-hot registered grant (bit0 = m0, bit1 = m1); 00 when idle.

Behaviour:
- Reset (async assert, sync-safe release):
  - state = IDLE, grant_o = 00, round-robin pointer favours m0, watchdog count = 0.
  - s_cyc_o, s_stb_o, s_we_o, all ack_o and err_o = 0.
  - s_adr_o and s_dat_o = 0 while idle.
- FSM states: IDLE, GNT0, GNT1. grant_o decodes the state.
- IDLE:
  - Only mX_cyc_i high → GNTX next cycle.
  - Both high → grant the master not served last (round-robin).
  - Neither high → stay in IDLE.
  - Arbitration latency: one cycle from cyc_i to grant.
- GNTX:
  - Slave outputs are a combinational mux of master X: s_cyc_o = mX_cyc_i, s_stb_o = mX_stb_i, plus we, adr and dat.
  - mX_ack_o = s_ack_i & mX_stb_i. The non-granted master sees ack = 0 and err = 0.
  - Grant is locked while mX_cyc_i = 1; the other master waits regardless of its request.
  - mX_cyc_i falls with mY_cyc_i high → GNTY directly, no idle cycle.
  - mX_cyc_i falls with mY_cyc_i low → IDLE.
  - On leaving GNTX, the pointer records X as last served.
- Watchdog:
  - Counts cycles in a GNT state with s_stb_o = 1 and s_ack_i = 0.
  - Clears on s_ack_i, on s_stb_o = 0, and on any grant change.
  - When the count reaches TIMEOUT: pulse mX_err_o for one cycle, force s_stb_o = 0 that same cycle, clear the count.
  - Grant is retained; the master decides whether to retry or drop cyc.
- s_ack_i arriving in the same cycle as the timeout: ack wins, no err.
- s_ack_i while in IDLE, or while the granted master's stb is low: ignored, not forwarded.
- Reset asserted mid-transfer: immediately IDLE; all slave controls drop in the same cycle (asynchronous).

Decomposition:
- Shared package gumnut_bus_pkg:
  - arb_state_t enum {IDLE, GNT0, GNT1}.
  - GNT_NONE/GNT_M0/GNT_M1 2-bit constants.
  - Default ADDR_W/DATA_W localparams for reuse by other bus blocks.
- One sub-module gumnut_bus_watchdog:
  - Parameterised by TIMEOUT.
  - Inputs: clk_i, rst_ni, count_en, clr. Output: expire (single-cycle pulse).
  - Counter width $clog2(TIMEOUT+1).
- Arbiter top: FSM, round-robin pointer and output muxing (about 150–200 lines).

Test Plan:
- m0 read only, adr 8'h3C, slave returns 8'hA5 with ack after 2 cycles → grant_o = 01 one cycle after cyc; m0_dat_o = A5 with m0_ack_o = 1 for one cycle; m1_ack_o = 0 throughout.
- m0 and m1 raise cyc in the same cycle after reset, each does one write and drops cyc → m0 granted first; m1 granted on the cycle m0_cyc_i falls, with no IDLE gap. A repeat of both raising cyc simultaneously then grants m1 first.
- m1 holds cyc for a 4-transfer burst (adr 10..13) while m0 requests → grant_o stays 10 for all 4 acks; m0 is granted only after m1_cyc_i drops.
- Slave never acks m0 strobe, TIMEOUT = 15 → m0_err_o pulses on the 15th stalled cycle; s_stb_o = 0 that cycle; grant_o stays 01. With ack on cycle 15 instead → ack seen, no err.
- rst_ni pulled low during a pending m1 write → s_cyc_o, s_stb_o and grant_o go to 0 without waiting for a clock edge; after release, the first request from m0 is granted normally.
- Spurious s_ack_i in IDLE → no ack or err on either master; state stays IDLE.

Source files
------------

// File: rtl/gumnut_bus_pkg.sv
// Shared types and constants for the Gumnut 8-bit data bus blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gumnut_bus_pkg;

    // Default bus geometry, reused by other blocks hanging off the data bus
    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 8;

    // Arbiter FSM: idle or holding the bus for one master
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // One-hot grant encodings (bit0 = m0, bit1 = m1)
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Grant vector implied by an arbiter state
    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            GNT0:    return GNT_M0;
            GNT1:    return GNT_M1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gumnut_bus_watchdog.sv
// Stall watchdog: counts enabled cycles and flags the TIMEOUT-th consecutive one.
// Latency: expire is combinational in the TIMEOUT-th enabled cycle; count clears that cycle.
// Backpressure: none; clr has priority over counting and suppresses expire.
module gumnut_bus_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic count_en,
    input  logic clr,
    output logic expire
);

    localparam int                CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Count holds the number of stalled cycles already seen, so the
    // TIMEOUT-th stalled cycle is the one where count == TIMEOUT-1.
    assign expire = count_en & ~clr & (count == LIMIT);

    // Stall counter: restart on clear or on expiry, else advance while enabled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clr || expire) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gumnut_data_arbiter.sv
// Two-master round-robin arbiter for the Gumnut data bus, grant locked for the whole cyc.
// Latency: one cycle from cyc to grant; slave signals are a combinational mux once granted.
// Backpressure: the losing master simply waits; a stalled strobe is terminated by err after TIMEOUT cycles.
module gumnut_data_arbiter
    import gumnut_bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // master 0: core data port
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    // master 1: secondary requester
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    // slave
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        grant_o
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       last_m1;      // 1 when m1 was the most recently served master

    logic              in_gnt;
    logic              sel_m1;
    logic              g_cyc;
    logic              g_stb;
    logic              g_we;
    logic [ADDR_W-1:0] g_adr;
    logic [DATA_W-1:0] g_dat;
    logic              wd_en;
    logic              wd_expire;

    assign in_gnt = (state != IDLE);
    assign sel_m1 = (state == GNT1);

    // Granted master's bus signals
    assign g_cyc = sel_m1 ? m1_cyc_i : m0_cyc_i;
    assign g_stb = sel_m1 ? m1_stb_i : m0_stb_i;
    assign g_we  = sel_m1 ? m1_we_i  : m0_we_i;
    assign g_adr = sel_m1 ? m1_adr_i : m0_adr_i;
    assign g_dat = sel_m1 ? m1_dat_i : m0_dat_i;

    // Read data is broadcast; ack gating decides who actually consumes it
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // A stall is a granted, strobing cycle without ack. Anything else
    // (ack, strobe low, cyc dropped ahead of a grant change, idle) clears it,
    // and an ack in the expiry cycle masks the error.
    assign wd_en = in_gnt & g_cyc & g_stb & ~s_ack_i;

    gumnut_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .count_en (wd_en),
        .clr      (~wd_en),
        .expire   (wd_expire)
    );

    // Next-state: round-robin on a tie from idle, hold while the owner keeps cyc,
    // hand over directly to a waiting master when the owner releases
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last_m1 ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_nxt = GNT0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_nxt = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_nxt = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, registered grant and last-served pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            grant_o <= GNT_NONE;
            last_m1 <= 1'b1;          // pretend m1 went last so m0 wins the first tie
        end else begin
            state   <= state_nxt;
            grant_o <= grant_of(state_nxt);
            if (state == GNT0 && state_nxt != GNT0) begin
                last_m1 <= 1'b0;
            end else if (state == GNT1 && state_nxt != GNT1) begin
                last_m1 <= 1'b1;
            end
        end
    end

    // Slave-side mux and per-master ack/err steering; everything is zero while idle
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        if (in_gnt) begin
            s_cyc_o  = g_cyc;
            s_stb_o  = g_stb & ~wd_expire;   // abort the strobe in the timeout cycle
            s_we_o   = g_we;
            s_adr_o  = g_adr;
            s_dat_o  = g_dat;
            m0_ack_o = ~sel_m1 & s_ack_i & m0_stb_i;
            m1_ack_o =  sel_m1 & s_ack_i & m1_stb_i;
            m0_err_o = ~sel_m1 & wd_expire;
            m1_err_o =  sel_m1 & wd_expire;
        end
    end

endmodule

// File: tb/tb_gumnut_data_arbiter.sv
// Scoreboard bench for gumnut_data_arbiter with a latency-programmable slave model.
// Latency: n/a.
// Backpressure: slave ack latency and a never-ack mode are set per scenario.
module tb_gumnut_data_arbiter;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;

    logic [1:0] cyc;
    logic [1:0] stb;
    logic [1:0] we;
    logic [7:0] adr [2];
    logic [7:0] dat [2];

    logic [7:0] m0_dat_o, m1_dat_o;
    logic       m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic       s_cyc_o, s_stb_o, s_we_o;
    logic [7:0] s_adr_o, s_dat_o, s_dat_i;
    logic       s_ack_i;
    logic [1:0] grant_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       m;
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] ref_mem [256];
    bit         err_allowed = 1'b0;

    // slave model controls
    bit         slave_auto = 1'b1;
    int         slave_lat  = 1;
    bit         spur_ack   = 1'b0;
    int         stb_cnt    = 0;
    logic [7:0] smem [256];
    logic [255:0] wr_seen = '0;

    always #5 clk_i = ~clk_i;

    gumnut_data_arbiter #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (15)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .m0_cyc_i (cyc[0]),
        .m0_stb_i (stb[0]),
        .m0_we_i  (we[0]),
        .m0_adr_i (adr[0]),
        .m0_dat_i (dat[0]),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (cyc[1]),
        .m1_stb_i (stb[1]),
        .m1_we_i  (we[1]),
        .m1_adr_i (adr[1]),
        .m1_dat_i (dat[1]),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .grant_o  (grant_o)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h3C) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    // Slave: acks the (slave_lat+1)-th consecutive strobe cycle, stores writes
    assign s_ack_i = spur_ack | (slave_auto && s_cyc_o && (stb_cnt == slave_lat));
    assign s_dat_i = wr_seen[s_adr_o] ? smem[s_adr_o] : init_val(s_adr_o);

    always @(posedge clk_i) begin
        if (s_stb_o && s_ack_i && s_we_o) begin
            smem[s_adr_o]    <= s_dat_o;
            wr_seen[s_adr_o] <= 1'b1;
        end
        stb_cnt <= (s_stb_o && !s_ack_i) ? stb_cnt + 1 : 0;
    end

    // Scoreboard monitor: every master ack must match the oldest expectation
    exp_t       mon_e;
    logic [7:0] mon_d;
    logic       mon_m;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (m0_ack_o || m1_ack_o) begin
                checks++;
                mon_m = m1_ack_o;
                if (m0_ack_o && m1_ack_o) begin
                    errors++;
                    $display("FAIL ack_both: m0_ack=1 m1_ack=1, required at most one");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b, required none", m0_ack_o, m1_ack_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_d = mon_e.we ? s_dat_o : (mon_m ? m1_dat_o : m0_dat_o);
                    if (mon_m !== mon_e.m || s_adr_o !== mon_e.adr || s_we_o !== mon_e.we || mon_d !== mon_e.dat) begin
                        errors++;
                        $display("FAIL xfer: got m%0d adr=%h we=%0b dat=%h, required m%0d adr=%h we=%0b dat=%h",
                                 mon_m, s_adr_o, s_we_o, mon_d, mon_e.m, mon_e.adr, mon_e.we, mon_e.dat);
                    end
                end
            end
            if (!err_allowed && (m0_err_o || m1_err_o)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_err: m0_err=%0b m1_err=%0b, required 0", m0_err_o, m1_err_o);
            end
        end
    end

    // One master transfer: push expectation, strobe, wait for ack, release
    task automatic run_xfer(input int m, input logic w, input logic [7:0] a,
                            input logic [7:0] d, input bit drop, output bit ok);
        exp_t e;
        @(posedge clk_i); #1;
        e.m   = (m == 1);
        e.we  = w;
        e.adr = a;
        e.dat = w ? d : ref_mem[a];
        if (w) ref_mem[a] = d;
        exp_q.push_back(e);
        stb[m] = 1'b1; we[m] = w; adr[m] = a; dat[m] = d;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_i);
            ok = (m == 1) ? m1_ack_o : m0_ack_o;
        end
        @(posedge clk_i); #1;
        stb[m] = 1'b0; we[m] = 1'b0;
        if (drop) cyc[m] = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b, required 00", grant_o); end
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
        end
        checks++;
        if ({s_adr_o, s_dat_o} !== 16'h0) begin errors++; $display("FAIL reset_bus: got adr=%h dat=%h, required 00 00", s_adr_o, s_dat_o); end
        #11 rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b, required 00", grant_o); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        slave_lat = 1;
        @(posedge clk_i); #1;
        cyc = 2'b11;
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b00) begin errors++; $display("FAIL sim_latency: got %b, required 00", grant_o); end
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b01) begin errors++; $display("FAIL sim_first_m0: got %b, required 01", grant_o); end
        run_xfer(0, 1'b1, 8'h20, 8'h11, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sim_m0_ack: got no ack, required ack within 40 cycles"); end
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b01) begin errors++; $display("FAIL sim_hold: got %b, required 01", grant_o); end
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b10) begin errors++; $display("FAIL sim_handoff: got %b, required 10", grant_o); end
        run_xfer(1, 1'b1, 8'h21, 8'h22, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sim_m1_ack: got no ack, required ack within 40 cycles"); end
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b00) begin errors++; $display("FAIL sim_idle: got %b, required 00", grant_o); end
    endtask

    task automatic test_m0_read();
        bit ok;
        slave_lat = 2;
        @(posedge clk_i); #1;
        cyc[0] = 1'b1;
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b00) begin errors++; $display("FAIL rd_latency: got %b, required 00", grant_o); end
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b01) begin errors++; $display("FAIL rd_grant: got %b, required 01", grant_o); end
        run_xfer(0, 1'b0, 8'h3C, 8'h00, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rd_ack: got no ack, required ack within 40 cycles"); end
        @(negedge clk_i);
        checks++;
        if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL rd_ack_single: got %b, required 0", m0_ack_o); end
    endtask

    task automatic test_rr_repeat();
        bit ok;
        slave_lat = 1;
        @(posedge clk_i); #1;
        cyc = 2'b11;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b10) begin errors++; $display("FAIL rr_first_m1: got %b, required 10", grant_o); end
        run_xfer(1, 1'b1, 8'h30, 8'h5E, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_m1_ack: got no ack, required ack within 40 cycles"); end
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b01) begin errors++; $display("FAIL rr_handoff: got %b, required 01", grant_o); end
        run_xfer(0, 1'b0, 8'h30, 8'h00, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_m0_ack: got no ack, required ack within 40 cycles"); end
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_burst();
        bit ok;
        slave_lat = 1;
        @(posedge clk_i); #1;
        cyc[1] = 1'b1;
        @(posedge clk_i); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 8'h12;   // m0 strobes while locked out
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b10) begin errors++; $display("FAIL burst_grant: got %b, required 10", grant_o); end
        for (int k = 0; k < 4; k++) begin
            run_xfer(1, 1'b1, 8'h10 + 8'(k), 8'hC0 + 8'(k), (k == 3), ok);
            checks++;
            if (!ok || (k < 3 && grant_o !== 2'b10)) begin
                errors++;
                $display("FAIL burst_beat%0d: got ack=%0b grant=%b, required ack=1 grant=10", k, ok, grant_o);
            end
        end
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b10) begin errors++; $display("FAIL burst_hold: got %b, required 10", grant_o); end
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b01) begin errors++; $display("FAIL burst_m0_next: got %b, required 01", grant_o); end
        run_xfer(0, 1'b0, 8'h12, 8'h00, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL burst_readback: got no ack, required ack within 40 cycles"); end
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b00) begin errors++; $display("FAIL burst_idle: got %b, required 00", grant_o); end
    endtask

    task automatic test_timeout();
        exp_t e;
        err_allowed = 1'b1;
        slave_auto  = 1'b0;
        @(posedge clk_i); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 8'h3C;
        @(posedge clk_i);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_i);
            checks++;
            if (grant_o !== 2'b01 || m0_err_o !== (k == 15) || s_stb_o !== (k != 15) || m1_err_o !== 1'b0 || s_cyc_o !== 1'b1) begin
                errors++;
                $display("FAIL timeout_cyc%0d: got grant=%b err0=%b err1=%b stb=%b cyc=%b, required grant=01 err0=%b err1=0 stb=%b cyc=1",
                         k, grant_o, m0_err_o, m1_err_o, s_stb_o, s_cyc_o, (k == 15), (k != 15));
            end
        end
        @(posedge clk_i); #1;
        stb[0] = 1'b0;
        @(posedge clk_i); #1;
        e.m = 1'b0; e.we = 1'b0; e.adr = 8'h3C; e.dat = ref_mem[8'h3C];
        exp_q.push_back(e);
        slave_auto = 1'b1;
        slave_lat  = 14;
        stb[0]     = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk_i);
            checks++;
            if (m0_ack_o !== (k == 15) || m0_err_o !== 1'b0) begin
                errors++;
                $display("FAIL ack_vs_timeout_cyc%0d: got ack=%b err=%b, required ack=%b err=0", k, m0_ack_o, m0_err_o, (k == 15));
            end
        end
        @(posedge clk_i); #1;
        stb[0] = 1'b0; cyc[0] = 1'b0;
        err_allowed = 1'b0;
        slave_lat   = 1;
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        bit ok;
        slave_auto = 1'b0;
        @(posedge clk_i); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h40; dat[1] = 8'h77;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b10 || s_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pending: got grant=%b stb=%b, required grant=10 stb=1", grant_o, s_stb_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_async: got cyc=%b stb=%b grant=%b, required 0 0 00", s_cyc_o, s_stb_o, grant_o);
        end
        cyc = 2'b00; stb = 2'b00; we = 2'b00;
        @(posedge clk_i); #2;
        rst_ni     = 1'b1;
        slave_auto = 1'b1;
        slave_lat  = 1;
        @(posedge clk_i); #1;
        cyc[0] = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b01) begin errors++; $display("FAIL rstmid_regrant: got %b, required 01", grant_o); end
        run_xfer(0, 1'b0, 8'h3C, 8'h00, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_ack: got no ack, required ack within 40 cycles"); end
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_spurious_ack();
        @(posedge clk_i); #1;
        spur_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checks++;
            if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0 || grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
                errors++;
                $display("FAIL spurious_ack%0d: got acks/errs=%b grant=%b cyc=%b, required 0000 00 0",
                         k, {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, grant_o, s_cyc_o);
            end
        end
        @(posedge clk_i); #1;
        spur_ack = 1'b0;
        @(negedge clk_i);
        checks++;
        if (grant_o !== 2'b00) begin errors++; $display("FAIL spurious_idle: got %b, required 00", grant_o); end
    endtask

    // Absolute bound so the bench can never hang
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        cyc = 2'b00; stb = 2'b00; we = 2'b00;
        adr[0] = 8'h00; adr[1] = 8'h00; dat[0] = 8'h00; dat[1] = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        test_reset();
        test_simultaneous();
        test_m0_read();
        test_rr_repeat();
        test_burst();
        test_timeout();
        test_reset_mid();
        test_spurious_ack();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
